// File: rtl/selector_pkg.sv
// Parameters, width helpers and state encoding shared by the input selector and its register bank.
package selector_pkg;

    localparam int unsigned DEF_DATA_WIDTH      = 4;
    localparam int unsigned DEF_OUTPUTS         = 4;
    localparam int unsigned DEF_OUTPUTS_PER_BUS = 4;
    localparam int unsigned DEF_REGS_INPUTS     = 64;

    function automatic int unsigned bus_w(int unsigned opb, int unsigned dw);
        return opb * dw;
    endfunction

    function automatic int unsigned word_w(int unsigned outs, int unsigned opb, int unsigned dw);
        return outs * opb * dw;
    endfunction

    function automatic int unsigned slots(int unsigned regs, int unsigned outs, int unsigned opb);
        return regs / (outs * opb);
    endfunction

    function automatic int unsigned ptr_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/output_reg_bank_if.sv
// Write-beat / register-readback bundle between the input selector and output_reg_bank.
interface output_reg_bank_if
    import selector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned REGS_INPUTS     = DEF_REGS_INPUTS,
    parameter int unsigned OUTPUTS         = DEF_OUTPUTS,
    parameter int unsigned OUTPUTS_PER_BUS = DEF_OUTPUTS_PER_BUS
);
    localparam int unsigned BUS_W  = bus_w(OUTPUTS_PER_BUS, DATA_WIDTH);
    localparam int unsigned REGS_W = REGS_INPUTS * DATA_WIDTH;
    localparam int unsigned PTR_W  = ptr_w(slots(REGS_INPUTS, OUTPUTS, OUTPUTS_PER_BUS));

    logic              wValid;
    logic              wClear;
    logic [BUS_W-1:0]  r0;
    logic [BUS_W-1:0]  r1;
    logic [BUS_W-1:0]  r2;
    logic [BUS_W-1:0]  r3;
    logic [REGS_W-1:0] wRegs;
    logic              wBusy;
    logic [PTR_W-1:0]  wWritePtr;
    logic              wFull;
    logic              wOverrun;

    modport master (
        output wValid, wClear, r0, r1, r2, r3,
        input  wRegs, wBusy, wWritePtr, wFull, wOverrun
    );

    modport slave (
        input  wValid, wClear, r0, r1, r2, r3,
        output wRegs, wBusy, wWritePtr, wFull, wOverrun
    );

endinterface

// File: rtl/reg_bank_slot.sv
// One bank slot: a word register with write-enable and synchronous clear (clear wins).
module reg_bank_slot #(
    parameter int unsigned WORD_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              clr,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/output_reg_bank.sv
// Slot-addressed capture bank for selector output beats, with a one-slot-per-cycle clear FSM.
// Define REG_BANK_WRAP_EN to make the bank a ring that overwrites the oldest slot instead of filling.
module output_reg_bank
    import selector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned REGS_INPUTS     = DEF_REGS_INPUTS,
    parameter int unsigned OUTPUTS         = DEF_OUTPUTS,
    parameter int unsigned OUTPUTS_PER_BUS = DEF_OUTPUTS_PER_BUS
) (
    input logic              clk,
    input logic              rst_n,
    output_reg_bank_if.slave bus
);

    localparam int unsigned WORD_W = word_w(OUTPUTS, OUTPUTS_PER_BUS, DATA_WIDTH);
    localparam int unsigned SLOTS  = slots(REGS_INPUTS, OUTPUTS, OUTPUTS_PER_BUS);
    localparam int unsigned PTR_W  = ptr_w(SLOTS);
    localparam int unsigned REGS_W = REGS_INPUTS * DATA_WIDTH;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(SLOTS - 1);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   cnt_q, cnt_d;
    logic               full_q, full_d;
    logic               ovr_q, ovr_d;
    logic               pend_q, pend_d;
    logic [SLOTS-1:0]   we;
    logic [SLOTS-1:0]   clr;
    logic [WORD_W-1:0]  beat;
    logic [WORD_W-1:0]  slot_q [SLOTS];
    logic [REGS_W-1:0]  regs_flat;

    assign beat = {bus.r3, bus.r2, bus.r1, bus.r0};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        ovr_d   = ovr_q;
        pend_d  = pend_q;
        we      = '0;
        clr     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.wClear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (bus.wValid) begin
`ifdef REG_BANK_WRAP_EN
                    we[ptr_q] = 1'b1;
                    ptr_d     = ptr_q + PTR_W'(1);
`else
                    if (!full_q) begin
                        we[ptr_q] = 1'b1;
                        ptr_d     = ptr_q + PTR_W'(1);
                        if (ptr_q == LAST) full_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
`endif
                end
            end
            ST_CLEAR: begin
                clr[cnt_q] = 1'b1;
                cnt_d      = cnt_q + PTR_W'(1);
                // Beats dropped mid-clear are remembered so the overrun survives the final zeroing.
                if (bus.wValid) pend_d = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                    full_d  = 1'b0;
                    ovr_d   = pend_q | bus.wValid;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            ovr_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            ovr_q   <= ovr_d;
            pend_q  <= pend_d;
        end
    end

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        reg_bank_slot #(
            .WORD_W(WORD_W)
        ) u_slot (
            .clk  (clk),
            .rst_n(rst_n),
            .we   (we[s]),
            .clr  (clr[s]),
            .d    (beat),
            .q    (slot_q[s])
        );
    end

    always_comb begin
        regs_flat = '0;
        for (int s = 0; s < SLOTS; s++) begin
            regs_flat[s*WORD_W +: WORD_W] = slot_q[s];
        end
    end

    assign bus.wRegs     = regs_flat;
    assign bus.wBusy     = (state_q == ST_CLEAR);
    assign bus.wWritePtr = ptr_q;
    assign bus.wFull     = full_q;
    assign bus.wOverrun  = ovr_q;

endmodule

// File: tb/tb_output_reg_bank.sv
// Directed bench for output_reg_bank: per-cycle comparison against a slot-array model plus literals.
module tb_output_reg_bank;

`ifdef REG_BANK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam int SLOTS = 4;

    localparam logic [63:0] B0 = 64'hfedcba9876543210;
    localparam logic [63:0] B1 = 64'h0123456789abcdef;
    localparam logic [63:0] B2 = 64'hdeadbeefcafef00d;
    localparam logic [63:0] B3 = 64'h5a5a5a5aa5a5a5a5;
    localparam logic [63:0] B5 = 64'h1111111111111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_reg_bank_if bus ();

    output_reg_bank dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Model: bank as an array of words, a clear as "slots left to zero".
    logic [63:0] m_slot [SLOTS];
    int          m_ptr;
    bit          m_full;
    bit          m_ovr;
    bit          m_pend;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) m_slot[i] <= '0;
            m_ptr  <= 0;
            m_full <= 1'b0;
            m_ovr  <= 1'b0;
            m_pend <= 1'b0;
            m_left <= 0;
        end else if (m_left != 0) begin
            m_slot[SLOTS - m_left] <= '0;
            m_left <= m_left - 1;
            if (bus.wValid) m_pend <= 1'b1;
            if (m_left == 1) begin
                m_ptr  <= 0;
                m_full <= 1'b0;
                m_ovr  <= m_pend || bus.wValid;
                m_pend <= 1'b0;
            end
        end else if (bus.wClear) begin
            m_left <= SLOTS;
        end else if (bus.wValid) begin
            if (WRAP || !m_full) begin
                m_slot[m_ptr] <= {bus.r3, bus.r2, bus.r1, bus.r0};
                m_ptr <= (m_ptr + 1) % SLOTS;
                if (!WRAP && m_ptr == SLOTS - 1) m_full <= 1'b1;
            end else begin
                m_ovr <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [255:0] exp_regs;
        for (int i = 0; i < SLOTS; i++) exp_regs[i*64 +: 64] = m_slot[i];
        chk("cyc_regs", bus.wRegs, exp_regs);
        chk("cyc_busy", {255'd0, bus.wBusy}, {255'd0, m_left != 0});
        chk("cyc_ptr", {254'd0, bus.wWritePtr}, 256'(m_ptr));
        chk("cyc_full", {255'd0, bus.wFull}, {255'd0, m_full});
        chk("cyc_ovr", {255'd0, bus.wOverrun}, {255'd0, m_ovr});
    end

    task automatic beat(input logic [63:0] w);
        @(negedge clk);
        {bus.r3, bus.r2, bus.r1, bus.r0} = w;
        bus.wValid = 1'b1;
        @(negedge clk);
        bus.wValid = 1'b0;
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        bus.wClear = 1'b1;
        @(negedge clk);
        bus.wClear = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.wBusy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_bound", {255'd0, bus.wBusy}, 256'd0);
    endtask

    initial begin
        int n_busy;
        bus.wValid = 1'b0;
        bus.wClear = 1'b0;
        {bus.r3, bus.r2, bus.r1, bus.r0} = '0;
        repeat (2) @(negedge clk);
        chk("rst_regs", bus.wRegs, 256'd0);
        chk("rst_ptr", {254'd0, bus.wWritePtr}, 256'd0);
        rst_n = 1'b1;

        beat(B0);
        chk("b0_slot0", {192'd0, bus.wRegs[63:0]}, {192'd0, 64'hfedcba9876543210});
        chk("b0_ptr", {254'd0, bus.wWritePtr}, 256'd1);
        beat(B1);
        beat(B2);
        beat(B3);
        chk("fill_slot3", {192'd0, bus.wRegs[255:192]}, {192'd0, B3});
        chk("fill_ptr", {254'd0, bus.wWritePtr}, 256'd0);
        chk("fill_full", {255'd0, bus.wFull}, {255'd0, !WRAP});

        beat(B5);
        chk("b5_slot0", {192'd0, bus.wRegs[63:0]}, {192'd0, WRAP ? B5 : B0});
        chk("b5_ovr", {255'd0, bus.wOverrun}, {255'd0, !WRAP});
        chk("b5_ptr", {254'd0, bus.wWritePtr}, WRAP ? 256'd1 : 256'd0);

        clear_pulse();
        n_busy = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.wBusy) n_busy++;
            @(negedge clk);
        end
        chk("clr_busy_cycles", 256'(n_busy), 256'd4);
        chk("clr_regs", bus.wRegs, 256'd0);
        chk("clr_ptr", {254'd0, bus.wWritePtr}, 256'd0);
        chk("clr_full", {255'd0, bus.wFull}, 256'd0);
        chk("clr_ovr", {255'd0, bus.wOverrun}, 256'd0);

        // Clear and beat in the same idle cycle: the beat must vanish without an overrun.
        beat(B0);
        @(negedge clk);
        {bus.r3, bus.r2, bus.r1, bus.r0} = B1;
        bus.wValid = 1'b1;
        bus.wClear = 1'b1;
        @(negedge clk);
        bus.wValid = 1'b0;
        bus.wClear = 1'b0;
        chk("cv_busy", {255'd0, bus.wBusy}, 256'd1);
        chk("cv_slot1", {192'd0, bus.wRegs[127:64]}, 256'd0);
        chk("cv_ptr", {254'd0, bus.wWritePtr}, 256'd1);
        wait_idle();
        chk("cv_ovr", {255'd0, bus.wOverrun}, 256'd0);

        // Beats held during a clear are dropped but leave the overrun set.
        clear_pulse();
        {bus.r3, bus.r2, bus.r1, bus.r0} = B2;
        bus.wValid = 1'b1;
        wait_idle();
        bus.wValid = 1'b0;
        chk("vc_ovr", {255'd0, bus.wOverrun}, 256'd1);
        chk("vc_regs", bus.wRegs, 256'd0);
        chk("vc_ptr", {254'd0, bus.wWritePtr}, 256'd0);

        // Reset in the second clear cycle, while slot 1 still holds data.
        beat(B3);
        beat(B1);
        clear_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_regs", bus.wRegs, 256'd0);
        chk("ar_busy", {255'd0, bus.wBusy}, 256'd0);
        chk("ar_ptr", {254'd0, bus.wWritePtr}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(B2);
        chk("ar_slot0", {192'd0, bus.wRegs[63:0]}, {192'd0, 64'hdeadbeefcafef00d});
        chk("ar_ptr1", {254'd0, bus.wWritePtr}, 256'd1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
